// File: rtl/map_pkg.sv
// Shared slot-type encodings, default frame geometry and scheduler state type for the sender mapper.
package map_pkg;

   typedef logic [1:0] slot_type_t;

   localparam slot_type_t SLOT_OH   = 2'b00;
   localparam slot_type_t SLOT_PYLD = 2'b01;
   localparam slot_type_t SLOT_PAD  = 2'b10;
   localparam slot_type_t SLOT_FILL = 2'b11;

   localparam int DEF_NUM_COLS   = 1041;
   localparam int DEF_OH_COLS    = 16;
   localparam int DEF_PAD_COLS   = 1;
   localparam int DEF_NUM_ROWS   = 4;
   localparam int DEF_COL_W      = 11;
   localparam int DEF_ROW_W      = 2;
   localparam int DEF_FILL_CNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } sched_state_t;

endpackage

// File: rtl/map_slot_scheduler_if.sv
// Slot scheduler bus: FIFO status/retransmit inputs in, registered slot descriptor and payload pop out.
interface map_slot_scheduler_if
   import map_pkg::*;
#(
   parameter int COL_W = DEF_COL_W,
   parameter int ROW_W = DEF_ROW_W
);
   logic             i_pyld_data_valid;
   logic             i_line_fifo_ready;
   logic             i_tran_rec_fifo_ready;
   logic             i_line_retrans_req;
   logic             o_data_req;
   logic             o_slot_vld;
   slot_type_t       o_slot_type;
   logic [COL_W-1:0] o_col_cnt;
   logic [ROW_W-1:0] o_row_cnt;
   logic             o_sof;

   modport master (
      output i_pyld_data_valid, i_line_fifo_ready, i_tran_rec_fifo_ready, i_line_retrans_req,
      input  o_data_req, o_slot_vld, o_slot_type, o_col_cnt, o_row_cnt, o_sof
   );

   modport slave (
      input  i_pyld_data_valid, i_line_fifo_ready, i_tran_rec_fifo_ready, i_line_retrans_req,
      output o_data_req, o_slot_vld, o_slot_type, o_col_cnt, o_row_cnt, o_sof
   );
endinterface

// File: rtl/frame_pos_counter.sv
// Row/column position counters for one frame; advance on adv, wrapping column then row.
// Zero latency: col/row/eof reflect the current position, the update lands on the next edge.
module frame_pos_counter #(
   parameter int NUM_COLS = 1041,
   parameter int NUM_ROWS = 4,
   parameter int COL_W    = 11,
   parameter int ROW_W    = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             adv,
   output logic [COL_W-1:0] col,
   output logic [ROW_W-1:0] row,
   output logic             eof
);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

   logic eor;

   assign eor = (col == LAST_COL);
   assign eof = eor && (row == LAST_ROW);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         col <= '0;
         row <= '0;
      end else if (adv) begin
         if (eor) begin
            col <= '0;
            row <= eof ? '0 : row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end
endmodule

// File: rtl/map_slot_scheduler.sv
// Frame-slot scheduler: classifies each slot (OH/PYLD/PAD/FILL) and pops the payload FIFO, 1-cycle registered.
// Stalls (holds position) whenever a downstream FIFO is not ready or a retransmission is in progress.
module map_slot_scheduler
   import map_pkg::*;
#(
   parameter int NUM_COLS   = DEF_NUM_COLS,
   parameter int OH_COLS    = DEF_OH_COLS,
   parameter int PAD_COLS   = DEF_PAD_COLS,
   parameter int NUM_ROWS   = DEF_NUM_ROWS,
   parameter int COL_W      = DEF_COL_W,
   parameter int ROW_W      = DEF_ROW_W,
   parameter int FILL_CNT_W = DEF_FILL_CNT_W
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_en,
   map_slot_scheduler_if.slave   bus,
   output logic                  o_busy,
   output logic [FILL_CNT_W-1:0] o_fill_cnt
);
   if (OH_COLS + PAD_COLS >= NUM_COLS) begin : g_bad_geometry
      $fatal(1, "map_slot_scheduler: OH_COLS + PAD_COLS must be less than NUM_COLS");
   end

   localparam logic [COL_W-1:0] OH_END    = COL_W'(OH_COLS);
   localparam logic [COL_W-1:0] PAD_START = COL_W'(NUM_COLS - PAD_COLS);

   sched_state_t     state, state_nxt;
   logic             go;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic             eof;
   slot_type_t       cls;

   assign go = bus.i_line_fifo_ready && bus.i_tran_rec_fifo_ready &&
               !bus.i_line_retrans_req && (state != ST_IDLE);
   assign o_busy = (state != ST_IDLE);

   frame_pos_counter #(
      .NUM_COLS (NUM_COLS),
      .NUM_ROWS (NUM_ROWS),
      .COL_W    (COL_W),
      .ROW_W    (ROW_W)
   ) u_pos (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .adv   (go),
      .col   (col),
      .row   (row),
      .eof   (eof)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Dropping i_en only arms DRAIN; IDLE is reached solely by consuming the last slot of a frame.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (i_en) state_nxt = ST_RUN;
         ST_RUN:   if (!i_en) state_nxt = ST_DRAIN;
         ST_DRAIN: begin
            if (i_en)           state_nxt = ST_RUN;
            else if (go && eof) state_nxt = ST_IDLE;
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      cls = SLOT_FILL;
      if (col < OH_END)                cls = SLOT_OH;
      else if (col >= PAD_START)       cls = SLOT_PAD;
      else if (bus.i_pyld_data_valid)  cls = SLOT_PYLD;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         bus.o_slot_vld  <= 1'b0;
         bus.o_data_req  <= 1'b0;
         bus.o_slot_type <= SLOT_OH;
         bus.o_col_cnt   <= '0;
         bus.o_row_cnt   <= '0;
         bus.o_sof       <= 1'b0;
         o_fill_cnt      <= '0;
      end else begin
         bus.o_slot_vld  <= go;
         bus.o_data_req  <= go && (cls == SLOT_PYLD);
         bus.o_slot_type <= go ? cls : SLOT_OH;
         bus.o_sof       <= go && (col == '0) && (row == '0);
         if (go) begin
            bus.o_col_cnt <= col;
            bus.o_row_cnt <= row;
         end
         if (go && (cls == SLOT_FILL) && !(&o_fill_cnt))
            o_fill_cnt <= o_fill_cnt + FILL_CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_map_slot_scheduler.sv
// Directed bench for map_slot_scheduler on a 40x2 frame (4 OH, 33 PYLD, 3 PAD per row).
module tb_map_slot_scheduler;
   import map_pkg::*;

   localparam int NC = 40, OH = 4, PAD = 3, NR = 2, CW = 6, RW = 1, FW = 4;

   logic          clk = 1'b0;
   logic          rst, en, busy;
   logic [FW-1:0] fill_cnt;
   int            checks = 0, failures = 0;
   int            nc = 0, nr = 0;
   bit            fill_on = 1'b0;
   slot_type_t    et;

   map_slot_scheduler_if #(.COL_W(CW), .ROW_W(RW)) bus ();

   map_slot_scheduler #(
      .NUM_COLS(NC), .OH_COLS(OH), .PAD_COLS(PAD), .NUM_ROWS(NR),
      .COL_W(CW), .ROW_W(RW), .FILL_CNT_W(FW)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_en(en), .bus(bus), .o_busy(busy), .o_fill_cnt(fill_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic advance_pos();
      if (nc == NC - 1) begin
         nc = 0;
         nr = (nr == NR - 1) ? 0 : nr + 1;
      end else begin
         nc++;
      end
   endtask

   function automatic slot_type_t exp_type(int c, int r);
      if (c < OH) return SLOT_OH;
      if (c >= NC - PAD) return SLOT_PAD;
      if (fill_on && r == 1 && c >= 10 && c <= 19) return SLOT_FILL;
      return SLOT_PYLD;
   endfunction

   task automatic test_reset();
      rst = 1'b1; en = 1'b0;
      bus.i_pyld_data_valid = 1'b1; bus.i_line_fifo_ready = 1'b1;
      bus.i_tran_rec_fifo_ready = 1'b1; bus.i_line_retrans_req = 1'b0;
      repeat (2) tick();
      checks++;
      if ({bus.o_slot_vld, bus.o_data_req, bus.o_sof, busy} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags got vld/req/sof/busy=%b need 0000",
                  {bus.o_slot_vld, bus.o_data_req, bus.o_sof, busy});
      end
      checks++;
      if (bus.o_slot_type !== SLOT_OH || bus.o_col_cnt !== '0 || bus.o_row_cnt !== '0) begin
         failures++;
         $display("FAIL reset_pos got type=%0d col=%0d row=%0d need 0 0 0",
                  bus.o_slot_type, bus.o_col_cnt, bus.o_row_cnt);
      end
      checks++;
      if (fill_cnt !== '0) begin
         failures++;
         $display("FAIL reset_fill_cnt got %0d need 0", fill_cnt);
      end
      rst = 1'b0;
   endtask

   task automatic test_full_frame();
      int got = 0, first = -1, nreq = 0;
      en = 1'b1;
      tick();
      checks++;
      if (bus.o_slot_vld !== 1'b0) begin
         failures++;
         $display("FAIL frame_pre_go got vld=%b need 0", bus.o_slot_vld);
      end
      for (int cyc = 0; cyc < 200 && got < NC * NR; cyc++) begin
         tick();
         nreq += int'(bus.o_data_req);
         if (bus.o_slot_vld) begin
            if (first < 0) first = cyc;
            et = exp_type(nc, nr);
            checks++;
            if (bus.o_slot_type !== et || bus.o_col_cnt !== CW'(nc) || bus.o_row_cnt !== RW'(nr) ||
                bus.o_sof !== (nc == 0 && nr == 0) || bus.o_data_req !== (et == SLOT_PYLD)) begin
               failures++;
               $display("FAIL frame_slot got type=%0d col=%0d row=%0d sof=%b req=%b need type=%0d col=%0d row=%0d",
                        bus.o_slot_type, bus.o_col_cnt, bus.o_row_cnt, bus.o_sof, bus.o_data_req, et, nc, nr);
            end
            advance_pos();
            got++;
         end
      end
      checks++;
      if (got != NC * NR || first != 0) begin
         failures++;
         $display("FAIL frame_count got slots=%0d first_cyc=%0d need 80 and 0", got, first);
      end
      checks++;
      if (nreq != 66) begin
         failures++;
         $display("FAIL frame_data_req got %0d need 66", nreq);
      end
   endtask

   task automatic test_fill();
      int got = 0, cycles = 0, nfill = 0, nreq = 0;
      fill_on = 1'b1;
      bus.i_pyld_data_valid = 1'b1;
      for (int cyc = 0; cyc < 400 && got < 2 * NC * NR; cyc++) begin
         tick();
         cycles++;
         nreq += int'(bus.o_data_req);
         if (bus.o_slot_vld) begin
            et = exp_type(nc, nr);
            if (bus.o_slot_type == SLOT_FILL) nfill++;
            checks++;
            if (bus.o_slot_type !== et || bus.o_col_cnt !== CW'(nc) || bus.o_row_cnt !== RW'(nr) ||
                bus.o_sof !== (nc == 0 && nr == 0) || bus.o_data_req !== (et == SLOT_PYLD)) begin
               failures++;
               $display("FAIL fill_slot got type=%0d col=%0d row=%0d sof=%b req=%b need type=%0d col=%0d row=%0d",
                        bus.o_slot_type, bus.o_col_cnt, bus.o_row_cnt, bus.o_sof, bus.o_data_req, et, nc, nr);
            end
            advance_pos();
            got++;
            if (got == NC * NR) begin
               checks++;
               if (fill_cnt !== 4'd10) begin
                  failures++;
                  $display("FAIL fill_cnt_one_frame got %0d need 10", fill_cnt);
               end
            end
         end
         bus.i_pyld_data_valid = !(nr == 1 && nc >= 10 && nc <= 19);
      end
      fill_on = 1'b0;
      bus.i_pyld_data_valid = 1'b1;
      checks++;
      if (fill_cnt !== 4'd15) begin
         failures++;
         $display("FAIL fill_cnt_saturate got %0d need 15", fill_cnt);
      end
      checks++;
      if (got != 160 || cycles != 160 || nfill != 20 || nreq != 112) begin
         failures++;
         $display("FAIL fill_rate got slots=%0d cycles=%0d fills=%0d reqs=%0d need 160 160 20 112",
                  got, cycles, nfill, nreq);
      end
   endtask

   task automatic test_retrans();
      int got = 0, idle = 0, holds = 0;
      for (int cyc = 0; cyc < 200 && got < NC * NR; cyc++) begin
         tick();
         if (bus.o_slot_vld) begin
            et = exp_type(nc, nr);
            checks++;
            if (bus.o_slot_type !== et || bus.o_col_cnt !== CW'(nc) || bus.o_row_cnt !== RW'(nr) ||
                bus.o_sof !== (nc == 0 && nr == 0) || bus.o_data_req !== (et == SLOT_PYLD)) begin
               failures++;
               $display("FAIL retrans_slot got type=%0d col=%0d row=%0d sof=%b req=%b need type=%0d col=%0d row=%0d",
                        bus.o_slot_type, bus.o_col_cnt, bus.o_row_cnt, bus.o_sof, bus.o_data_req, et, nc, nr);
            end
            advance_pos();
            got++;
         end else begin
            idle++;
         end
         if (nr == 0 && nc == 20 && holds < 5) begin
            bus.i_line_retrans_req = 1'b1;
            holds++;
         end else begin
            bus.i_line_retrans_req = 1'b0;
         end
      end
      checks++;
      if (got != NC * NR || idle != 5) begin
         failures++;
         $display("FAIL retrans_gap got slots=%0d idle=%0d need 80 and 5", got, idle);
      end
   endtask

   task automatic test_drain();
      int got = 0;
      for (int cyc = 0; cyc < 200 && got < NC * NR; cyc++) begin
         tick();
         if (bus.o_slot_vld) begin
            et = exp_type(nc, nr);
            checks++;
            if (bus.o_slot_type !== et || bus.o_col_cnt !== CW'(nc) || bus.o_row_cnt !== RW'(nr) ||
                bus.o_sof !== (nc == 0 && nr == 0) || bus.o_data_req !== (et == SLOT_PYLD)) begin
               failures++;
               $display("FAIL drain_slot got type=%0d col=%0d row=%0d sof=%b req=%b need type=%0d col=%0d row=%0d",
                        bus.o_slot_type, bus.o_col_cnt, bus.o_row_cnt, bus.o_sof, bus.o_data_req, et, nc, nr);
            end
            advance_pos();
            got++;
            if (got == 60) begin
               checks++;
               if (busy !== 1'b1) begin
                  failures++;
                  $display("FAIL drain_busy_mid got %b need 1", busy);
               end
            end
         end
         if (nr == 0 && nc == 20) en = 1'b0;
      end
      checks++;
      if (got != NC * NR || busy !== 1'b0) begin
         failures++;
         $display("FAIL drain_end got slots=%0d busy=%b need 80 and 0", got, busy);
      end
      repeat (3) tick();
      checks++;
      if ({bus.o_slot_vld, bus.o_data_req, busy} !== 3'b000 ||
          bus.o_col_cnt !== CW'(NC - 1) || bus.o_row_cnt !== RW'(NR - 1)) begin
         failures++;
         $display("FAIL drain_idle got vld/req/busy=%b col=%0d row=%0d need 000 col=39 row=1",
                  {bus.o_slot_vld, bus.o_data_req, busy}, bus.o_col_cnt, bus.o_row_cnt);
      end
   endtask

   task automatic test_toggle_ready();
      int got = 0, last = -1, nreq = 0;
      en = 1'b1;
      tick();
      checks++;
      if (bus.o_slot_vld !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL restart_pre_go got vld=%b busy=%b need 0 1", bus.o_slot_vld, busy);
      end
      for (int cyc = 0; cyc < 400 && got < NC * NR; cyc++) begin
         tick();
         nreq += int'(bus.o_data_req);
         if (bus.o_slot_vld) begin
            last = cyc;
            et = exp_type(nc, nr);
            checks++;
            if (bus.o_slot_type !== et || bus.o_col_cnt !== CW'(nc) || bus.o_row_cnt !== RW'(nr) ||
                bus.o_sof !== (nc == 0 && nr == 0) || bus.o_data_req !== (et == SLOT_PYLD)) begin
               failures++;
               $display("FAIL toggle_slot got type=%0d col=%0d row=%0d sof=%b req=%b need type=%0d col=%0d row=%0d",
                        bus.o_slot_type, bus.o_col_cnt, bus.o_row_cnt, bus.o_sof, bus.o_data_req, et, nc, nr);
            end
            advance_pos();
            got++;
         end
         bus.i_line_fifo_ready = ~bus.i_line_fifo_ready;
      end
      bus.i_line_fifo_ready = 1'b1;
      checks++;
      if (got != NC * NR || last != 2 * NC * NR - 2 || nreq != 66) begin
         failures++;
         $display("FAIL toggle_stretch got slots=%0d last_cyc=%0d reqs=%0d need 80 158 66", got, last, nreq);
      end
   endtask

   task automatic test_reset_mid_frame();
      bit hit = 1'b0;
      for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
         tick();
         if (bus.o_slot_vld) advance_pos();
         hit = (nr == 1 && nc == 30);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (!hit || {bus.o_slot_vld, bus.o_data_req, bus.o_sof, busy} !== 4'b0000 ||
          bus.o_slot_type !== SLOT_OH || bus.o_col_cnt !== '0 || bus.o_row_cnt !== '0 || fill_cnt !== '0) begin
         failures++;
         $display("FAIL mid_reset got hit=%b vld/req/sof/busy=%b type=%0d col=%0d row=%0d fill=%0d need all 0",
                  hit, {bus.o_slot_vld, bus.o_data_req, bus.o_sof, busy}, bus.o_slot_type,
                  bus.o_col_cnt, bus.o_row_cnt, fill_cnt);
      end
      rst = 1'b0;
      nc = 0; nr = 0;
      tick();
      checks++;
      if (bus.o_slot_vld !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_pre_go got vld=%b need 0", bus.o_slot_vld);
      end
      tick();
      checks++;
      if (bus.o_slot_vld !== 1'b1 || bus.o_sof !== 1'b1 || bus.o_col_cnt !== '0 ||
          bus.o_row_cnt !== '0 || bus.o_slot_type !== SLOT_OH) begin
         failures++;
         $display("FAIL mid_reset_restart got vld=%b sof=%b col=%0d row=%0d type=%0d need 1 1 0 0 0",
                  bus.o_slot_vld, bus.o_sof, bus.o_col_cnt, bus.o_row_cnt, bus.o_slot_type);
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_fill();
      test_retrans();
      test_drain();
      test_toggle_ready();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
